// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight register writes across the post-decode
// stages and the MDU busy window, and produces the D-stage stall and forwarding selects.
module hazard_scoreboard #(
  parameter  int STAGES  = 3,
  parameter  int AW      = 5,
  parameter  int TW      = 2,
  parameter  int MUL_LAT = 5,
  parameter  int DIV_LAT = 10,
  localparam int SW      = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_wr_en,
  input  logic [AW-1:0] d_wr_addr,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_is_div,
  input  logic          d_md_use,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
  } entry_t;

  // Index 0 is the E-stage entry; higher indices are older instructions.
  entry_t [STAGES-1:0] sb_q, sb_d;
  logic   [CW-1:0]     md_cnt_q, md_cnt_d;

  logic          haz_rs, haz_rt;
  logic [SW-1:0] sel_rs, sel_rt;
  logic          accept;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

  // Youngest matching entry decides both the stall and the forward select.
  function automatic void lookup(
    input  entry_t [STAGES-1:0] sb,
    input  logic   [AW-1:0]     src,
    input  logic                use_src,
    input  logic   [TW-1:0]     tuse,
    output logic                hazard,
    output logic   [SW-1:0]     sel
  );
    logic found;
    found  = 1'b0;
    hazard = 1'b0;
    sel    = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (!found && use_src && (src != '0) && sb[k].v && (sb[k].addr == src)) begin
        found  = 1'b1;
        hazard = (sb[k].tnew > tuse);
        sel    = (sb[k].tnew == '0) ? SW'(k + 1) : '0;
      end
    end
  endfunction

  always_comb begin
    lookup(sb_q, d_rs, d_use_rs, d_tuse_rs, haz_rs, sel_rs);
    lookup(sb_q, d_rt, d_use_rt, d_tuse_rt, haz_rt, sel_rt);
  end

  assign md_busy    = (md_cnt_q != '0);
  assign stall      = d_valid & (haz_rs | haz_rt | ((d_md_use | d_md_start) & md_busy));
  assign fwd_rs_sel = sel_rs;
  assign fwd_rt_sel = sel_rt;
  assign accept     = d_valid & ~stall;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    sb_d = '0;
    if (accept && d_wr_en && (d_wr_addr != '0)) begin
      sb_d[0].v    = 1'b1;
      sb_d[0].addr = d_wr_addr;
      sb_d[0].tnew = d_tnew;
    end
    for (int k = 1; k < STAGES; k++) begin
      sb_d[k]      = sb_q[k-1];
      sb_d[k].tnew = sat_dec(sb_q[k-1].tnew);
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (accept && d_md_start) begin
      md_cnt_d = d_md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q     <= '0;
      md_cnt_q <= '0;
    end else begin
      sb_q     <= sb_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule
